// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bundle: request/lock/transfer-status inputs and grant/owner outputs.
// Latency: none (wires only).
// Backpressure: HREADY from the selected slave stalls owner updates inside the arbiter.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] HBUSREQx;
  logic [NUM_MASTERS-1:0] HLOCKx;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [15:0]            HSPLITx;
  logic [NUM_MASTERS-1:0] HGRANTx;
  logic [3:0]             HMASTER;
  logic                   HMASTLOCK;

  // Bus side: masters/slaves drive requests and transfer status, observe grant.
  modport master (
    output HBUSREQx, HLOCKx, HTRANS, HBURST, HREADY, HRESP, HSPLITx,
    input  HGRANTx, HMASTER, HMASTLOCK
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQx, HLOCKx, HTRANS, HBURST, HREADY, HRESP, HSPLITx,
    output HGRANTx, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst tracking, locked transfers and SPLIT masking.
// Latency: grant registered one edge after an arbitration point; HMASTER/HMASTLOCK one HREADY cycle later.
// Backpressure: HREADY=0 freezes beat counter, owner registers and suppresses arbitration.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [1:0] RESP_SPLIT   = 2'b11;
  localparam logic [3:0] DEF_IDX      = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] GRANT_RST = (NUM_MASTERS)'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] mask_set;
  logic [NUM_MASTERS-1:0] mask_nxt;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] sel_onehot;
  logic [15:0]            req16;
  logic [15:0]            lock16;
  logic [15:0]            elig16;
  logic [3:0]             last_granted;
  logic [3:0]             sel_idx;
  logic [3:0]             beat_cnt;
  logic [3:0]             beat_nxt;
  logic [3:0]             hmaster_q;
  logic [4:0]             cand;
  logic                   found;
  logic                   hmastlock_q;
  logic                   arb_started;
  logic                   split_trig;
  logic                   lock_hold;
  logic                   burst_open;
  logic                   arb_pt_run;
  logic                   arb_pt;
  logic                   arb_go;
  logic                   unused_split;

  assign req16        = 16'(bus.HBUSREQx);
  assign lock16       = 16'(bus.HLOCKx);
  assign unused_split = ^bus.HSPLITx;

  // SPLIT is acted on in the second response cycle, when HREADY is high.
  assign split_trig = bus.HREADY && (bus.HRESP == RESP_SPLIT);

  // Master being split this cycle is excluded from selection alongside already-masked ones.
  always_comb begin
    mask_set = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mask_set[i] = split_trig && (hmaster_q == 4'(i));
    end
  end

  assign eligible = bus.HBUSREQx & ~split_mask & ~mask_set;
  assign elig16   = 16'(eligible);

  // Round-robin search starting just after the last granted master; default if nobody eligible.
  always_comb begin
    sel_idx = DEF_IDX;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = 5'(last_granted) + 5'(k);
      if (cand >= 5'(NUM_MASTERS)) cand = cand - 5'(NUM_MASTERS);
      if (!found && elig16[cand[3:0]]) begin
        sel_idx = cand[3:0];
        found   = 1'b1;
      end
    end
  end

  // One-hot decode of the selected index.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_onehot[i] = (sel_idx == 4'(i));
    end
  end

  // Lock hold keeps the bus with the current owner while it both locks and requests.
  assign lock_hold  = lock16[last_granted] && req16[last_granted];
  assign burst_open = (bus.HBURST[2:1] == 2'b00);

  assign arb_pt_run = bus.HREADY &&
                      ((bus.HTRANS == TRANS_IDLE) ||
                       ((bus.HTRANS == TRANS_NONSEQ) && burst_open) ||
                       ((bus.HTRANS == TRANS_SEQ) && (bus.HBURST == BURST_INCR)) ||
                       ((bus.HTRANS == TRANS_SEQ) && (beat_cnt == 4'd1)));

  // Out of reset the bus state is not trusted until an IDLE cycle has been seen.
  assign arb_pt = arb_started ? arb_pt_run : (bus.HREADY && (bus.HTRANS == TRANS_IDLE));
  assign arb_go = split_trig || (arb_pt && !lock_hold);

  // Remaining-beat count for fixed-length bursts.
  always_comb begin
    beat_nxt = beat_cnt;
    if (bus.HREADY && (bus.HTRANS == TRANS_NONSEQ)) begin
      case (bus.HBURST[2:1])
        2'b01:   beat_nxt = 4'd3;
        2'b10:   beat_nxt = 4'd7;
        2'b11:   beat_nxt = 4'd15;
        default: beat_nxt = 4'd0;
      endcase
    end else if (bus.HREADY && (bus.HTRANS == TRANS_SEQ) && (beat_cnt != 4'd0)) begin
      beat_nxt = beat_cnt - 4'd1;
    end
  end

  // Set wins over a simultaneous resume of the same master.
  assign mask_nxt = (split_mask & ~bus.HSPLITx[NUM_MASTERS-1:0]) | mask_set;

  // Grant register: moves only at (forced) arbitration points.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q      <= GRANT_RST;
      last_granted <= DEF_IDX;
      arb_started  <= 1'b0;
    end else if (arb_go) begin
      grant_q      <= sel_onehot;
      last_granted <= sel_idx;
      arb_started  <= 1'b1;
    end
  end

  // Burst beat tracking.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) beat_cnt <= '0;
    else          beat_cnt <= beat_nxt;
  end

  // Split mask maintenance.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) split_mask <= '0;
    else          split_mask <= mask_nxt;
  end

  // Address-phase owner and lock follow the grant whenever the bus advances.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      hmaster_q   <= last_granted;
      hmastlock_q <= lock16[last_granted];
    end
  end

  assign bus.HGRANTx   = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus random traffic against a cycle reference model.
// Latency: outputs compared every cycle on the falling edge after the update edge.
// Backpressure: random HREADY low cycles exercise stalls.
module tb_ahb_arbiter;
  localparam int NM  = 4;
  localparam int DEF = 0;

  logic HCLK;
  logic HRESETn;
  int   n_checks;
  int   n_errors;

  // Reference model state
  int        m_last;
  int        m_cnt;
  int        m_hmaster;
  bit        m_mlock;
  bit        m_started;
  bit [15:0] m_mask;

  ahb_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last    = DEF;
    m_cnt     = 0;
    m_hmaster = DEF;
    m_mlock   = 1'b0;
    m_started = 1'b0;
    m_mask    = '0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit        st;
    bit        found;
    bit        hold;
    bit        arbp;
    int        sel;
    int        c;
    bit [15:0] nmask;
    st    = bus.HREADY && (bus.HRESP == 2'b11);
    sel   = DEF;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      c = (m_last + k) % NM;
      if (!found && bus.HBUSREQx[c] && !m_mask[c] && !(st && c == m_hmaster)) begin
        sel   = c;
        found = 1'b1;
      end
    end
    hold = bus.HLOCKx[m_last] && bus.HBUSREQx[m_last];
    if (!m_started)
      arbp = bus.HREADY && bus.HTRANS == 2'b00;
    else
      arbp = bus.HREADY && (bus.HTRANS == 2'b00 ||
                            (bus.HTRANS == 2'b10 && bus.HBURST <= 3'd1) ||
                            (bus.HTRANS == 2'b11 && bus.HBURST == 3'd1) ||
                            (bus.HTRANS == 2'b11 && m_cnt == 1));
    nmask = m_mask & ~bus.HSPLITx & 16'h000F;
    if (st) nmask[m_hmaster] = 1'b1;
    if (bus.HREADY) begin
      if (bus.HTRANS == 2'b10)
        m_cnt = (bus.HBURST >= 3'd6) ? 15 : (bus.HBURST >= 3'd4) ? 7 : (bus.HBURST >= 3'd2) ? 3 : 0;
      else if (bus.HTRANS == 2'b11 && m_cnt > 0)
        m_cnt = m_cnt - 1;
      m_mlock   = bus.HLOCKx[m_last];
      m_hmaster = m_last;
    end
    m_mask = nmask;
    if (st || (arbp && !hold)) begin
      m_last    = sel;
      m_started = 1'b1;
    end
  endtask

  task automatic check_all();
    check_val("grant",    32'(bus.HGRANTx), 32'(1) << m_last);
    check_val("onehot",   32'($onehot(bus.HGRANTx)), 32'd1);
    check_val("hmaster",  32'(bus.HMASTER), 32'(m_hmaster));
    check_val("mastlock", 32'(bus.HMASTLOCK), 32'(m_mlock));
    check_val("splitmsk", 32'(dut.split_mask), 32'(m_mask[NM-1:0]));
  endtask

  // One bus cycle: drive at the falling edge, clock, compare at the next falling edge.
  task automatic cyc(input logic [3:0] rq, input logic [3:0] lk, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rd, input logic [1:0] rs,
                     input logic [15:0] sp);
    bus.HBUSREQx = rq;
    bus.HLOCKx   = lk;
    bus.HTRANS   = tr;
    bus.HBURST   = bu;
    bus.HREADY   = rd;
    bus.HRESP    = rs;
    bus.HSPLITx  = sp;
    model_step();
    @(posedge HCLK);
    @(negedge HCLK);
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    HRESETn  = 1'b0;
    bus.HBUSREQx = '0; bus.HLOCKx = '0; bus.HTRANS = 2'b00; bus.HBURST = 3'b000;
    bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HSPLITx = '0;
    model_reset();
    repeat (3) @(negedge HCLK);
    check_val("rst_grant",    32'(bus.HGRANTx), 32'h1);
    check_val("rst_hmaster",  32'(bus.HMASTER), 32'd0);
    check_val("rst_mastlock", 32'(bus.HMASTLOCK), 32'd0);
    HRESETn = 1'b1;

    // Round robin, all requesting, SINGLE transfers after an initial IDLE.
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b0, (k == 0) ? 2'b00 : 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
      check_val("rr_seq", 32'(bus.HGRANTx), 32'(1) << ((k + 1) % 4));
    end

    // INCR8 burst by M2 with M1 waiting.
    cyc(4'b0100, 4'b0, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
    cyc(4'b0110, 4'b0, 2'b10, 3'b101, 1'b1, 2'b00, 16'h0);
    check_val("burst_start", 32'(bus.HGRANTx), 32'h4);
    for (int b = 2; b <= 8; b++) begin
      cyc(4'b0110, 4'b0, 2'b11, 3'b101, 1'b1, 2'b00, 16'h0);
      check_val("burst_grant", 32'(bus.HGRANTx), (b < 8) ? 32'h4 : 32'h2);
      check_val("burst_hmaster", 32'(bus.HMASTER), 32'd2);
    end
    cyc(4'b0010, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("burst_handover", 32'(bus.HMASTER), 32'd1);

    // Wait states during a grant change.
    cyc(4'b0001, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("ws_grant", 32'(bus.HGRANTx), 32'h1);
    for (int w = 0; w < 3; w++) begin
      cyc(4'b0001, 4'b0, 2'b00, 3'b000, 1'b0, 2'b00, 16'h0);
      check_val("ws_hold", 32'(bus.HMASTER), 32'd1);
    end
    cyc(4'b0001, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("ws_release", 32'(bus.HMASTER), 32'd0);

    // Locked sequence by M3 while M0 requests.
    cyc(4'b1000, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    for (int l = 0; l < 10; l++) begin
      cyc(4'b1001, 4'b1000, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
      check_val("lock_grant", 32'(bus.HGRANTx), 32'h8);
      check_val("lock_mastlock", 32'(bus.HMASTLOCK), 32'd1);
    end
    cyc(4'b1001, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("lock_release", 32'(bus.HGRANTx), 32'h1);

    // SPLIT of M1, then resume.
    cyc(4'b0010, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    cyc(4'b0010, 4'b0, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("split_owner", 32'(bus.HMASTER), 32'd1);
    cyc(4'b0011, 4'b0, 2'b00, 3'b000, 1'b1, 2'b11, 16'h0);
    check_val("split_mask_set", 32'(dut.split_mask), 32'h2);
    check_val("split_regrant", 32'(bus.HGRANTx), 32'h1);
    for (int s = 0; s < 2; s++) begin
      cyc(4'b0011, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
      check_val("split_excl", 32'(bus.HGRANTx), 32'h1);
    end
    cyc(4'b0011, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0002);
    check_val("split_clear", 32'(dut.split_mask), 32'h0);
    cyc(4'b0011, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("split_resume", 32'(bus.HGRANTx), 32'h2);

    // Reset during beat 3 of a locked WRAP16 with M1 split-masked.
    cyc(4'b0110, 4'b0, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
    cyc(4'b0100, 4'b0, 2'b00, 3'b000, 1'b1, 2'b11, 16'h0);
    cyc(4'b0100, 4'b0100, 2'b10, 3'b110, 1'b1, 2'b00, 16'h0);
    check_val("wrap_lock", 32'(bus.HMASTLOCK), 32'd1);
    cyc(4'b0100, 4'b0100, 2'b11, 3'b110, 1'b1, 2'b00, 16'h0);
    bus.HTRANS = 2'b11;
    #2 HRESETn = 1'b0;
    #1;
    check_val("arst_grant",    32'(bus.HGRANTx), 32'h1);
    check_val("arst_mastlock", 32'(bus.HMASTLOCK), 32'd0);
    check_val("arst_hmaster",  32'(bus.HMASTER), 32'd0);
    check_val("arst_mask",     32'(dut.split_mask), 32'h0);
    check_val("arst_beats",    32'(dut.beat_cnt), 32'h0);
    model_reset();
    @(negedge HCLK);
    check_all();
    HRESETn = 1'b1;

    // First arbitration after reset waits for an IDLE cycle.
    cyc(4'b0010, 4'b0, 2'b10, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("post_rst_wait", 32'(bus.HGRANTx), 32'h1);
    cyc(4'b0010, 4'b0, 2'b00, 3'b000, 1'b1, 2'b00, 16'h0);
    check_val("post_rst_idle", 32'(bus.HGRANTx), 32'h2);

    // Random traffic.
    for (int r = 0; r < 600; r++) begin
      logic [3:0]  rq;
      logic [3:0]  lk;
      logic [1:0]  rs;
      logic [15:0] sp;
      int          pick;
      rq   = 4'($urandom);
      lk   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      pick = $urandom_range(0, 7);
      rs   = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : (pick == 2) ? 2'b11 : 2'b00;
      sp   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
      cyc(rq, lk, 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0), rs, sp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
